// File: rtl/fpu_alu_arbiter.sv
// Two-requester arbiter sharing one signed-mantissa add/subtract ALU (IDLE/EXEC/RESP).
// Define FPU_ALU_ARB_RR_EN for round-robin arbitration; the default is fixed priority (requester 0 wins).

module fpu_big_alu #(
  parameter int WIDTH = 53
) (
  input  logic [WIDTH-1:0] a,
  input  logic             a_sign,
  input  logic [WIDTH-1:0] b,
  input  logic             b_sign,
  input  logic             op,
  output logic [WIDTH:0]   extended_result,
  output logic             result_sign
);

  logic           eff_b_sign;
  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;

  assign ext_a = {1'b0, a};
  assign ext_b = {1'b0, b};

  // Subtraction is addition with b's sign flipped; unlike signs reduce to a magnitude compare.
  always_comb begin
    eff_b_sign      = b_sign ^ op;
    extended_result = '0;
    result_sign     = 1'b0;
    if (a_sign == eff_b_sign) begin
      extended_result = ext_a + ext_b;
      result_sign     = a_sign;
    end else if (ext_a >= ext_b) begin
      extended_result = ext_a - ext_b;
      result_sign     = a_sign;
    end else begin
      extended_result = ext_b - ext_a;
      result_sign     = eff_b_sign;
    end
    if (extended_result == '0)
      result_sign = 1'b0;
  end

endmodule

module fpu_alu_arbiter #(
  parameter int WIDTH = 53
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_a_sign,
  input  logic [1:0]         req_b_sign,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH:0]     rsp_result,
  output logic               rsp_sign,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             owner;
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             a_sign_q;
  logic             b_sign_q;
  logic [1:0]       grant;
  logic [WIDTH:0]   alu_result;
  logic             alu_sign;

`ifdef FPU_ALU_ARB_RR_EN
  logic last_grant;

  always_comb begin
    grant = '0;
    if (state == IDLE && !rst) begin
      if (req_valid == 2'b11)
        grant = last_grant ? 2'b01 : 2'b10;
      else
        grant = req_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b1;
    else if (grant != '0)
      last_grant <= grant[1];
  end
`else
  always_comb begin
    grant = '0;
    if (state == IDLE && !rst) begin
      if (req_valid[0])
        grant = 2'b01;
      else if (req_valid[1])
        grant = 2'b10;
    end
  end
`endif

  assign req_ready = grant;
  assign busy      = (state != IDLE);

  fpu_big_alu #(.WIDTH(WIDTH)) u_alu (
    .a               (a_q),
    .a_sign          (a_sign_q),
    .b               (b_q),
    .b_sign          (b_sign_q),
    .op              (op_q),
    .extended_result (alu_result),
    .result_sign     (alu_sign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      a_sign_q   <= 1'b0;
      b_sign_q   <= 1'b0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_sign   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != '0) begin
            owner    <= grant[1];
            op_q     <= grant[1] ? req_op[1]               : req_op[0];
            a_q      <= grant[1] ? req_a[2*WIDTH-1:WIDTH]  : req_a[WIDTH-1:0];
            b_q      <= grant[1] ? req_b[2*WIDTH-1:WIDTH]  : req_b[WIDTH-1:0];
            a_sign_q <= grant[1] ? req_a_sign[1]           : req_a_sign[0];
            b_sign_q <= grant[1] ? req_b_sign[1]           : req_b_sign[0];
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_sign   <= alu_sign;
          rsp_valid  <= owner ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
